// File: rtl/dcp_pkg.sv
// Shared types and constants for the DCP responder.
// FSM encoding plus the mailbox register index.
package dcp_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_WR,
    S_RD,
    S_HOLD
  } state_t;

  localparam int unsigned MBOX_IDX = 0;

endpackage

// File: rtl/dcp_responder_if.sv
// CPU-side DCP strobe bus between the controller (master)
// and the register responder (slave).
interface dcp_responder_if #(
  parameter int DW = 8
);
  logic          mas_n;
  logic          mds_n;
  logic          rd;
  logic [DW-1:0] din;
  logic [DW-1:0] dout;
  logic          doe;

  modport master (
    output mas_n, mds_n, rd, din,
    input  dout, doe
  );

  modport slave (
    input  mas_n, mds_n, rd, din,
    output dout, doe
  );
endinterface

// File: rtl/dcp_regfile.sv
// 2**AW x DW register file: remote and local write ports
// (local wins on collision) and two combinational read ports.
module dcp_regfile #(
  parameter int DW = 8,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_rem_we,
  input  logic [AW-1:0] i_rem_addr,
  input  logic [DW-1:0] i_rem_wdata,
  output logic [DW-1:0] o_rem_rdata,
  input  logic          i_loc_we,
  input  logic [AW-1:0] i_loc_addr,
  input  logic [DW-1:0] i_loc_wdata,
  output logic [DW-1:0] o_loc_rdata
);

  localparam int NREG = 1 << AW;

  logic [DW-1:0] r_mem [NREG];

  // Local port is written last so it overrides a same-address remote write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) r_mem[i] <= '0;
    end else begin
      if (i_rem_we) r_mem[i_rem_addr] <= i_rem_wdata;
      if (i_loc_we) r_mem[i_loc_addr] <= i_loc_wdata;
    end
  end

  assign o_rem_rdata = r_mem[i_rem_addr];
  assign o_loc_rdata = r_mem[i_loc_addr];

endmodule

// File: rtl/dcp_responder.sv
// DCP bus responder: turns mas/mds strobe cycles into register
// accesses, with a mailbox irq on register 0 and a sticky error.
module dcp_responder
  import dcp_pkg::*;
#(
  parameter int DW = 8,
  parameter int AW = 4
) (
  input  logic           CLK,
  input  logic           SANITY_n,
  dcp_responder_if.slave bus,
  input  logic           loc_we,
  input  logic [AW-1:0]  loc_addr,
  input  logic [DW-1:0]  loc_wdata,
  output logic [DW-1:0]  loc_rdata,
  output logic           irq,
  input  logic           irq_clr,
  output logic           err
);

  state_t r_state, w_next;

  logic r_mas, r_mas_d, r_mas_arm;
  logic r_mds, r_mds_d, r_mds_arm;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_dout;
  logic r_doe, r_irq, r_err;

  logic w_mas_fall, w_mds_fall, w_both_lo;
  logic w_rem_we, w_addr_ld, w_addr_inc;
  logic w_rd_start, w_rd_end, w_err_set, w_irq_set;
  logic [DW-1:0] w_rem_rdata;

  // Arm bits block a strobe held low across reset from looking like an edge.
  always_ff @(posedge CLK or negedge SANITY_n) begin
    if (!SANITY_n) begin
      r_mas     <= 1'b1;
      r_mas_d   <= 1'b1;
      r_mas_arm <= 1'b0;
      r_mds     <= 1'b1;
      r_mds_d   <= 1'b1;
      r_mds_arm <= 1'b0;
    end else begin
      r_mas     <= bus.mas_n;
      r_mas_d   <= r_mas;
      r_mas_arm <= r_mas_arm | bus.mas_n;
      r_mds     <= bus.mds_n;
      r_mds_d   <= r_mds;
      r_mds_arm <= r_mds_arm | bus.mds_n;
    end
  end

  assign w_mas_fall = r_mas_d & ~r_mas & r_mas_arm;
  assign w_mds_fall = r_mds_d & ~r_mds & r_mds_arm;
  assign w_both_lo  = ~r_mas & ~r_mds;

  always_ff @(posedge CLK or negedge SANITY_n) begin
    if (!SANITY_n) r_state <= S_IDLE;
    else           r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_rem_we   = 1'b0;
    w_addr_ld  = 1'b0;
    w_addr_inc = 1'b0;
    w_rd_start = 1'b0;
    w_rd_end   = 1'b0;
    w_err_set  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if ((w_mas_fall | w_mds_fall) & w_both_lo) begin
          w_err_set = 1'b1;
          w_next    = S_HOLD;
        end else if (w_mas_fall) begin
          w_next = S_ADDR;
        end else if (w_mds_fall) begin
          w_rd_start = bus.rd;
          w_next     = bus.rd ? S_RD : S_WR;
        end
      end
      S_ADDR: begin
        w_addr_ld = 1'b1;
        w_next    = S_HOLD;
      end
      S_WR: begin
        w_rem_we   = 1'b1;
        w_addr_inc = 1'b1;
        w_next     = S_HOLD;
      end
      S_RD: begin
        if (r_mds) begin
          w_rd_end   = 1'b1;
          w_addr_inc = 1'b1;
          w_next     = S_HOLD;
        end
      end
      S_HOLD: begin
        if (r_mas & r_mds) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign w_irq_set = w_rem_we & (r_addr == AW'(MBOX_IDX));

  always_ff @(posedge CLK or negedge SANITY_n) begin
    if (!SANITY_n) begin
      r_addr <= '0;
      r_dout <= '0;
      r_doe  <= 1'b0;
      r_irq  <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      if (w_addr_ld)       r_addr <= bus.din[AW-1:0];
      else if (w_addr_inc) r_addr <= r_addr + 1'b1;
      if (w_rd_start) begin
        r_dout <= w_rem_rdata;
        r_doe  <= 1'b1;
      end else if (w_rd_end) begin
        r_doe  <= 1'b0;
      end
      r_irq <= w_irq_set | (r_irq & ~irq_clr);
      if (w_err_set) r_err <= 1'b1;
    end
  end

  dcp_regfile #(
    .DW(DW),
    .AW(AW)
  ) u_regfile (
    .clk        (CLK),
    .rst_n      (SANITY_n),
    .i_rem_we   (w_rem_we),
    .i_rem_addr (r_addr),
    .i_rem_wdata(bus.din),
    .o_rem_rdata(w_rem_rdata),
    .i_loc_we   (loc_we),
    .i_loc_addr (loc_addr),
    .i_loc_wdata(loc_wdata),
    .o_loc_rdata(loc_rdata)
  );

  assign bus.dout = r_dout;
  assign bus.doe  = r_doe;
  assign irq      = r_irq;
  assign err      = r_err;

endmodule
